// File: rtl/icap_reboot_ctrl_if.sv
// icap_reboot_ctrl_if: ICAPE3 command port (CSIB, RDWRB, bit-swapped I) between controller and primitive.
interface icap_reboot_ctrl_if;
  logic        icap_csib;
  logic        icap_rdwrb;
  logic [31:0] icap_i;
  modport master (output icap_csib, icap_rdwrb, icap_i);
  modport slave  (input  icap_csib, icap_rdwrb, icap_i);
endinterface

// File: rtl/icap_reboot_ctrl.sv
// icap_reboot_ctrl: thermal/manual warm-boot controller issuing an IPROG sequence on ICAPE3.
module icap_reboot_ctrl #(
  parameter int          TEMP_W      = 10,
  parameter int          NUM_CH      = 4,
  parameter int          THRESH_INIT = 732,
  parameter int          DEBOUNCE    = 4,
  parameter logic [31:0] WBSTAR_INIT = 32'h0000_0000,
  localparam int         CW          = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     reboot_req,
  input  logic [NUM_CH*TEMP_W-1:0] temp_in,
  input  logic                     temp_valid,
  input  logic [TEMP_W-1:0]        temp_thresh,
  input  logic                     thresh_valid,
  input  logic [31:0]              wbstar_in,
  input  logic                     wbstar_valid,
  icap_reboot_ctrl_if.master       icap,
  output logic                     busy,
  output logic [1:0]               trip_cause,
  output logic [CW-1:0]            trip_ch,
  output logic [NUM_CH-1:0]        over_temp
);
  typedef enum logic [1:0] {IDLE, ARM, SEQ, DONE} state_t;
  localparam logic [31:0] SEQ_W [8] = '{32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000, 32'h3002_0001,
                                        32'h0000_0000, 32'h2000_0000, 32'h3000_8001, 32'h0000_000F};
  function automatic logic [31:0] bswap(input logic [31:0] w);
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++) bswap[8*b+i] = w[8*b+7-i];
  endfunction
  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [TEMP_W-1:0]   thresh_q, thresh_d;
  logic [31:0]         wbstar_q, wbstar_d;
  logic [7:0]          cnt_q [NUM_CH];
  logic [7:0]          cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   over_q, over_d, ge, trip;
  logic [CW-1:0]       low_ch, trip_ch_q, trip_ch_d;
  logic [1:0]          cause_q, cause_d;
  logic                busy_q, busy_d, csib_q, csib_d;
  logic [31:0]         icap_i_q, icap_i_d;
  logic                idle, trig;
  // Trip decision uses the count this cycle's sample produces, so a trip lands with its 4th sample.
  always_comb begin
    ge = '0;
    trip = '0;
    over_d = over_q;
    cnt_d = cnt_q;
    low_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ge[k] = temp_in[k*TEMP_W +: TEMP_W] >= thresh_q;
      over_d[k] = temp_valid ? ge[k] : over_q[k];
      cnt_d[k] = !temp_valid ? cnt_q[k] : !ge[k] ? 8'd0 :
                 cnt_q[k] == 8'(DEBOUNCE) ? cnt_q[k] : cnt_q[k] + 8'd1;
      trip[k] = enable && cnt_d[k] == 8'(DEBOUNCE);
    end
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (trip[k]) low_ch = CW'(k);
  end
  assign idle = state_q == IDLE;
  assign trig = reboot_req || |trip;
  always_comb begin
    state_d = idle ? (trig ? ARM : IDLE) : state_q == ARM ? SEQ :
              state_q == SEQ ? (idx_q == 3'd7 ? DONE : SEQ) : DONE;
    idx_d = state_q == SEQ ? idx_q + 3'd1 : 3'd0;
  end
  always_comb begin
    thresh_d = idle && thresh_valid ? temp_thresh : thresh_q;
    wbstar_d = idle && !trig && wbstar_valid ? wbstar_in : wbstar_q;
    cause_d = idle && trig ? (reboot_req ? 2'b01 : 2'b10) : cause_q;
    trip_ch_d = idle && trig && !reboot_req ? low_ch : trip_ch_q;
    busy_d = state_d != IDLE;
    csib_d = state_d != SEQ;
    icap_i_d = state_d != SEQ ? 32'hFFFF_FFFF : bswap(idx_d == 3'd4 ? wbstar_q : SEQ_W[idx_d]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      thresh_q <= TEMP_W'(THRESH_INIT);
      wbstar_q <= WBSTAR_INIT;
      cnt_q <= '{default: '0};
      over_q <= '0;
      cause_q <= '0;
      trip_ch_q <= '0;
      busy_q <= 1'b0;
      csib_q <= 1'b1;
      icap_i_q <= 32'hFFFF_FFFF;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      thresh_q <= thresh_d;
      wbstar_q <= wbstar_d;
      cnt_q <= cnt_d;
      over_q <= over_d;
      cause_q <= cause_d;
      trip_ch_q <= trip_ch_d;
      busy_q <= busy_d;
      csib_q <= csib_d;
      icap_i_q <= icap_i_d;
    end
  end
  assign icap.icap_csib = csib_q;
  assign icap.icap_rdwrb = csib_q;
  assign icap.icap_i = icap_i_q;
  assign busy = busy_q;
  assign trip_cause = cause_q;
  assign trip_ch = trip_ch_q;
  assign over_temp = over_q;
endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// tb_icap_reboot_ctrl: directed checks of manual/thermal reboot, debounce, threshold, enable and reset abort.
module tb_icap_reboot_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, reboot_req = 1'b0, temp_valid = 1'b0;
  logic        thresh_valid = 1'b0, wbstar_valid = 1'b0;
  logic [39:0] temp_in = '0;
  logic [9:0]  temp_thresh = '0;
  logic [31:0] wbstar_in = '0;
  logic        busy;
  logic [1:0]  trip_cause;
  logic [1:0]  trip_ch;
  logic [3:0]  over_temp;
  int          errors = 0, checks = 0;
  logic [31:0] exp_w [8];
  icap_reboot_ctrl_if bus ();
  icap_reboot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .reboot_req(reboot_req),
    .temp_in(temp_in), .temp_valid(temp_valid), .temp_thresh(temp_thresh),
    .thresh_valid(thresh_valid), .wbstar_in(wbstar_in), .wbstar_valid(wbstar_valid),
    .icap(bus.master), .busy(busy), .trip_cause(trip_cause), .trip_ch(trip_ch),
    .over_temp(over_temp)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    {enable, reboot_req, temp_valid, thresh_valid, wbstar_valid} = '0;
    temp_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    exp_w = '{32'hFFFFFFFF, 32'h5599AA66, 32'h04000000, 32'h0C400080,
              32'h80000000, 32'h04000000, 32'h0C000180, 32'h000000F0};
    tick();
    chk("rst_csib", bus.icap_csib, 1);
    chk("rst_rdwrb", bus.icap_rdwrb, 1);
    chk("rst_i", bus.icap_i, 32'hFFFFFFFF);
    chk("rst_busy", busy, 0);
    chk("rst_cause", trip_cause, 0);
    chk("rst_ch", trip_ch, 0);
    chk("rst_over", over_temp, 0);
    do_reset();
    // manual reboot with WBSTAR 0x01000000
    wbstar_valid = 1'b1; wbstar_in = 32'h01000000;
    tick();
    wbstar_valid = 1'b0; reboot_req = 1'b1;
    tick();
    reboot_req = 1'b0;
    chk("man_busy", busy, 1);
    chk("man_cause", trip_cause, 2'b01);
    chk("man_csib_arm", bus.icap_csib, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("man_csib%0d", k), bus.icap_csib, 0);
      chk($sformatf("man_rdwrb%0d", k), bus.icap_rdwrb, 0);
      chk($sformatf("man_word%0d", k), bus.icap_i, exp_w[k]);
      if (k == 3) reboot_req = 1'b1;
    end
    reboot_req = 1'b0;
    tick();
    chk("man_done_csib", bus.icap_csib, 1);
    chk("man_done_rdwrb", bus.icap_rdwrb, 1);
    chk("man_done_i", bus.icap_i, 32'hFFFFFFFF);
    chk("man_done_busy", busy, 1);
    tick();
    chk("man_done_hold", bus.icap_csib, 1);
    do_reset();
    // thermal debounce on channel 2
    enable = 1'b1; temp_valid = 1'b1;
    temp_in[20 +: 10] = 10'd740;
    for (int k = 0; k < 3; k++) tick();
    chk("deb3_busy", busy, 0);
    chk("deb3_over", over_temp, 4'b0100);
    temp_in[20 +: 10] = 10'd700;
    tick();
    chk("deb_drop_busy", busy, 0);
    chk("deb_drop_over", over_temp, 0);
    temp_in[20 +: 10] = 10'd740;
    for (int k = 0; k < 3; k++) tick();
    chk("deb7_busy", busy, 0);
    tick();
    temp_valid = 1'b0;
    chk("therm_busy", busy, 1);
    chk("therm_cause", trip_cause, 2'b10);
    chk("therm_ch", trip_ch, 2);
    tick();
    chk("therm_csib", bus.icap_csib, 0);
    chk("therm_w0", bus.icap_i, 32'hFFFFFFFF);
    tick();
    chk("therm_w1", bus.icap_i, 32'h5599AA66);
    do_reset();
    // threshold reload to 800; 790 never trips, 800 is at threshold
    enable = 1'b1; thresh_valid = 1'b1; temp_thresh = 10'd800;
    tick();
    thresh_valid = 1'b0; temp_valid = 1'b1;
    temp_in = {4{10'd790}};
    for (int k = 0; k < 10; k++) tick();
    chk("thr_busy", busy, 0);
    chk("thr_over", over_temp, 0);
    temp_in[10 +: 10] = 10'd800;
    tick();
    chk("thr_eq_over", over_temp, 4'b0010);
    chk("thr_eq_busy", busy, 0);
    do_reset();
    // same-cycle threshold load compares against old threshold
    thresh_valid = 1'b1; temp_thresh = 10'd800; temp_valid = 1'b1;
    temp_in[0 +: 10] = 10'd740;
    tick();
    thresh_valid = 1'b0;
    chk("same_old_over", over_temp, 4'b0001);
    tick();
    chk("same_new_over", over_temp, 4'b0000);
    do_reset();
    // enable gating with channel 0 saturated
    temp_valid = 1'b1; temp_in[0 +: 10] = 10'd900;
    for (int k = 0; k < 6; k++) tick();
    temp_valid = 1'b0;
    chk("gate_busy", busy, 0);
    chk("gate_over", over_temp, 4'b0001);
    enable = 1'b1;
    tick();
    chk("gate_en_busy", busy, 1);
    chk("gate_en_cause", trip_cause, 2'b10);
    chk("gate_en_ch", trip_ch, 0);
    do_reset();
    // manual wins over simultaneous channel-3 trip, then reset mid-sequence
    enable = 1'b1; temp_valid = 1'b1; temp_in[30 +: 10] = 10'd900;
    for (int k = 0; k < 3; k++) tick();
    chk("sim_pre_busy", busy, 0);
    reboot_req = 1'b1;
    tick();
    reboot_req = 1'b0; temp_valid = 1'b0;
    chk("sim_busy", busy, 1);
    chk("sim_cause", trip_cause, 2'b01);
    for (int k = 0; k < 5; k++) tick();
    chk("sim_w4_csib", bus.icap_csib, 0);
    chk("sim_w4", bus.icap_i, 32'h00000000);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_csib", bus.icap_csib, 1);
    chk("abort_rdwrb", bus.icap_rdwrb, 1);
    chk("abort_i", bus.icap_i, 32'hFFFFFFFF);
    chk("abort_busy", busy, 0);
    chk("abort_cause", trip_cause, 0);
    tick();
    rst_n = 1'b1;
    enable = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("post_busy", busy, 0);
    chk("post_csib", bus.icap_csib, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
